// File: rtl/rr_grant_pkg.sv
// Shared state encoding for the round-robin grant controller.
package rr_grant_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'b001,
    GRANT   = 3'b010,
    RELEASE = 3'b100
  } state_e;

endpackage

// File: rtl/rr_grant_ctrl_wdt.sv
// Grant watchdog: counts cycles of the current grant and flags the last allowed one.
module grant_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic halt,
  output logic last,
  output logic busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // Terminal count: the counter reads TIMEOUT-1 during the TIMEOUT-th grant cycle.
  assign last = (cnt_q == CW'(TIMEOUT - 1));
  assign busy = busy_q;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (init) begin
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (halt || last) busy_d = 1'b0;
      else              cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin single-owner grant controller; watchdog compiled in with RR_GRANT_TIMEOUT_EN.
module rr_grant_ctrl
  import rr_grant_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     timeout_pulse,
  output logic                     busy
);

  // state   | meaning
  // IDLE    | no owner; pick next requester round-robin from last_id+1
  // GRANT   | owner holds resource until done[gnt_id] or watchdog expiry
  // RELEASE | one cycle with gnt=0 before arbitrating again

  localparam int IDW = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("rr_grant_ctrl: N_REQ must be >= 2 and TIMEOUT >= 1");
  end

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   last_id_q, last_id_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic [IDW-1:0]   pick_id;
  logic             pick_found;
  logic             done_own;
  logic             wdt_expire;

  assign done_own = (state_q == GRANT) && done[gnt_id_q];

`ifdef RR_GRANT_TIMEOUT_EN
  logic wdt_init, wdt_last, wdt_busy;
  assign wdt_init   = (state_q == IDLE) && (|req);
  assign wdt_expire = wdt_busy && wdt_last;

  grant_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
    .clk  (clk),
    .rst_n(rst_n),
    .init (wdt_init),
    .halt (done_own),
    .last (wdt_last),
    .busy (wdt_busy)
  );
`else
  assign wdt_expire = 1'b0;
`endif

  // First set request bit searching upward from last_id+1, wrapping at N_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!pick_found && req[(int'(last_id_q) + i) % N_REQ]) begin
        pick_found = 1'b1;
        pick_id    = IDW'((int'(last_id_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    gnt_id_d        = gnt_id_q;
    last_id_d       = last_id_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d          = '0;
          gnt_d[pick_id] = 1'b1;
          gnt_id_d       = pick_id;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        if (done_own || wdt_expire) begin
          gnt_d           = '0;
          last_id_d       = gnt_id_q;
          timeout_pulse_d = !done_own;
          state_d         = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      gnt_q           <= '0;
      gnt_valid_q     <= 1'b0;
      gnt_id_q        <= '0;
      last_id_q       <= IDW'(N_REQ - 1);
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      gnt_valid_q     <= gnt_valid_d;
      gnt_id_q        <= gnt_id_d;
      last_id_q       <= last_id_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign gnt           = gnt_q;
  assign gnt_valid     = gnt_valid_q;
  assign gnt_id        = gnt_id_q;
  assign timeout_pulse = timeout_pulse_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (N_REQ=4, TIMEOUT=8); watchdog checks follow RR_GRANT_TIMEOUT_EN.
module tb_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout_pulse;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  rr_grant_ctrl #(.N_REQ(4), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .done         (done),
    .gnt          (gnt),
    .gnt_valid    (gnt_valid),
    .gnt_id       (gnt_id),
    .timeout_pulse(timeout_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = '0;

    // reset holds everything low even with all requests raised
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_valid", gnt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tp", timeout_pulse, 0);
    chk("rst_gnt_id", gnt_id, 0);
    rst_n = 1'b1;
    tick();
    chk("first_gnt", gnt, 4'b0001);
    chk("first_busy", busy, 1);
    req  = '0;
    done = 4'b0001;
    tick();
    chk("first_rel_gnt", gnt, 0);
    chk("first_rel_valid", gnt_valid, 0);
    chk("first_rel_busy", busy, 1);
    done = '0;
    tick();
    chk("first_idle_busy", busy, 0);
    chk("first_idle_id", gnt_id, 0);

    // basic release: req 0101 in cycle t
    do_reset();
    req = 4'b0101;
    tick();                                   // t+1
    chk("basic_gnt0", gnt, 4'b0001);
    chk("basic_valid", gnt_valid, 1);
    tick();                                   // t+2
    tick();                                   // t+3
    done = 4'b0001;
    tick();                                   // t+4
    chk("basic_rel", gnt, 0);
    done = '0;
    tick();                                   // t+5
    chk("basic_idle", gnt, 0);
    chk("basic_idle_busy", busy, 0);
    tick();                                   // t+6
    chk("basic_gnt2", gnt, 4'b0100);
    chk("basic_id2", gnt_id, 2);
    req = '0;
    tick();
    chk("drop_req_held", gnt, 4'b0100);
    done = 4'b0001;
    tick();
    chk("foreign_done_held", gnt, 4'b0100);
    done = 4'b0100;
    tick();
    chk("basic_rel2", gnt, 0);
    chk("basic_rel2_tp", timeout_pulse, 0);
    done = '0;
    tick();

    // fairness: all requesting, owner releases in its second grant cycle
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (k % 4);
      tick();
      chk("fair_g1", gnt, exp_g);
      tick();
      chk("fair_g2", gnt, exp_g);
      done = exp_g;
      tick();
      chk("fair_rel", gnt, 0);
      done = '0;
      if (k == 4) req = '0;
      tick();
      chk("fair_idle", gnt, 0);
    end

`ifdef RR_GRANT_TIMEOUT_EN
    // watchdog forces release after exactly 8 grant cycles
    do_reset();
    req = 4'b0100;
    tick();
    chk("wdt_g1", gnt, 4'b0100);
    req = '0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("wdt_held", gnt, 4'b0100);
      chk("wdt_no_tp", timeout_pulse, 0);
    end
    tick();
    chk("wdt_rel_gnt", gnt, 0);
    chk("wdt_tp", timeout_pulse, 1);
    tick();
    chk("wdt_tp_clear", timeout_pulse, 0);
    chk("wdt_idle", busy, 0);

    // done in the 8th cycle wins over expiry
    req = 4'b0100;
    tick();
    chk("wdt2_g1", gnt, 4'b0100);
    req = '0;
    for (int i = 2; i <= 8; i++) tick();
    chk("wdt2_g8", gnt, 4'b0100);
    done = 4'b0100;
    tick();
    chk("wdt2_rel", gnt, 0);
    chk("wdt2_no_tp", timeout_pulse, 0);
    done = '0;
    tick();
`else
    // no watchdog: grant held indefinitely
    do_reset();
    req = 4'b0100;
    tick();
    chk("nowdt_g1", gnt, 4'b0100);
    req = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("nowdt_held", gnt, 4'b0100);
      chk("nowdt_tp", timeout_pulse, 0);
    end
    done = 4'b0100;
    tick();
    chk("nowdt_rel", gnt, 0);
    done = '0;
    tick();
`endif

    // foreign done ignored and dropped request keeps the grant
    do_reset();
    req = 4'b0001;
    tick();
    chk("ign_g1", gnt, 4'b0001);
    req  = '0;
    done = 4'b0010;
    tick();
    chk("ign_done1", gnt, 4'b0001);
    done = '0;
    tick();
    chk("ign_held", gnt, 4'b0001);
    chk("ign_busy", busy, 1);
    done = 4'b0001;
    req  = 4'b0100;
    tick();
    done = '0;
    tick();
    tick();
    chk("pre_rst_gnt2", gnt, 4'b0100);

    // asynchronous reset mid-grant
    rst_n = 1'b0;
    #2;
    chk("arst_gnt", gnt, 0);
    chk("arst_valid", gnt_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tp", timeout_pulse, 0);
    chk("arst_id", gnt_id, 0);
    tick();
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    chk("arst_next_gnt", gnt, 4'b0001);
    chk("arst_next_id", gnt_id, 0);
    req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
